// File: rtl/gate_tt_checker_pkg.sv
// Shared types and truth-table constants for the 2-input gate checker.
// Vector index i = {A,B}; bit i of a table is the expected Y for that vector.
package gate_check_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_SAMPLE,
    ST_DONE
  } state_t;

  localparam int CNT_W = 4;

  localparam logic [3:0] TT_AND  = 4'b1000;
  localparam logic [3:0] TT_OR   = 4'b1110;
  localparam logic [3:0] TT_NAND = 4'b0111;
  localparam logic [3:0] TT_NOR  = 4'b0001;
  localparam logic [3:0] TT_XOR  = 4'b0110;

endpackage

// File: rtl/gate_tt_checker_if.sv
// Checker <-> gate/controller signal bundle; master is the checker side.
// The gate under test returns Y combinationally from A/B.
interface gate_tt_checker_if;
  logic       start;
  logic       A;
  logic       B;
  logic       Y;
  logic       busy;
  logic       done;
  logic       pass;
  logic [2:0] err_count;
  logic [3:0] fail_mask;

  modport master (
    input  start, Y,
    output A, B, busy, done, pass, err_count, fail_mask
  );

  modport slave (
    output start, Y,
    input  A, B, busy, done, pass, err_count, fail_mask
  );
endinterface

// File: rtl/gate_tt_checker_settle_timer.sv
// Loadable 4-bit down-counter; load wins, otherwise counts down and holds at 0.
// zero is combinational from the count register; no backpressure.
module settle_timer
  import gate_check_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic             zero
);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (cnt != '0) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/gate_tt_checker.sv
// Sweeps {A,B} through 00..11, samples Y SETTLE+1 cycles after each vector, reports vs TT.
// Sweep takes 4*(SETTLE+1)+1 cycles to done; start is ignored while busy or in DONE.
module gate_tt_checker
  import gate_check_pkg::*;
#(
  parameter logic [3:0] TT     = TT_OR,
  parameter int         SETTLE = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  gate_tt_checker_if.master chk
);

  localparam logic [CNT_W-1:0] RELOAD = CNT_W'(SETTLE - 1);

  state_t     state, state_nxt;
  logic [1:0] idx, idx_nxt;
  logic       a_q, a_nxt, b_q, b_nxt;
  logic       busy_q, busy_nxt, done_q, done_nxt, pass_q, pass_nxt;
  logic [2:0] err_q, err_nxt;
  logic [3:0] mask_q, mask_nxt;
  logic       load, cnt_zero, miss;

  settle_timer u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (load),
    .load_val (RELOAD),
    .zero     (cnt_zero)
  );

  // Case inequality so an X/Z on Y is scored as a mismatch.
  assign miss = (chk.Y !== TT[idx]);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= ST_IDLE;
      idx    <= '0;
      a_q    <= 1'b0;
      b_q    <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      pass_q <= 1'b0;
      err_q  <= '0;
      mask_q <= '0;
    end else begin
      state  <= state_nxt;
      idx    <= idx_nxt;
      a_q    <= a_nxt;
      b_q    <= b_nxt;
      busy_q <= busy_nxt;
      done_q <= done_nxt;
      pass_q <= pass_nxt;
      err_q  <= err_nxt;
      mask_q <= mask_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    a_nxt     = a_q;
    b_nxt     = b_q;
    busy_nxt  = busy_q;
    done_nxt  = 1'b0;
    pass_nxt  = pass_q;
    err_nxt   = err_q;
    mask_nxt  = mask_q;
    load      = 1'b0;
    case (state)
      ST_IDLE: begin
        if (chk.start) begin
          err_nxt   = '0;
          mask_nxt  = '0;
          pass_nxt  = 1'b0;
          busy_nxt  = 1'b1;
          idx_nxt   = '0;
          a_nxt     = 1'b0;
          b_nxt     = 1'b0;
          load      = 1'b1;
          state_nxt = ST_SETTLE;
        end
      end
      ST_SETTLE: begin
        if (cnt_zero) state_nxt = ST_SAMPLE;
      end
      ST_SAMPLE: begin
        if (miss) begin
          mask_nxt[idx] = 1'b1;
          err_nxt       = err_q + 3'd1;
        end
        if (idx != 2'd3) begin
          idx_nxt        = idx + 2'd1;
          {a_nxt, b_nxt} = idx + 2'd1;
          load           = 1'b1;
          state_nxt      = ST_SETTLE;
        end else begin
          state_nxt = ST_DONE;
        end
      end
      ST_DONE: begin
        done_nxt  = 1'b1;
        busy_nxt  = 1'b0;
        pass_nxt  = (err_q == 3'd0);
        state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  assign chk.A         = a_q;
  assign chk.B         = b_q;
  assign chk.busy      = busy_q;
  assign chk.done      = done_q;
  assign chk.pass      = pass_q;
  assign chk.err_count = err_q;
  assign chk.fail_mask = mask_q;

endmodule

// File: doc/gate_tt_checker.md
# gate_tt_checker

Sequential stimulus-and-check stage that sits directly upstream of a 2-input combinational gate under test (OR, AND, NAND, NOR, XOR in the basic_gates set). On a start pulse it drives all four input combinations onto the gate's A/B inputs and waits a programmable settle time. It then samples the gate's Y output and compares it against a parameterised expected truth table. It reports pass/fail, an error count and a per-vector failure mask, so gate checks run as synthesizable clocked logic rather than delay-based testbench code.

## Interface
- TT, 4'b1110, expected truth table; bit i is the expected Y for vector i = {A,B} (default = OR)
- SETTLE, 2, cycles between applying a vector and sampling Y; legal range 1..15

- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  begin a sweep; sampled only in IDLE
- A  out  1  gate input A; vector bit 1
- B  out  1  gate input B; vector bit 0
- Y  in  1  gate output under test
- busy  out  1  high from sweep start until the final sample
- done  out  1  one-cycle pulse when results become valid
- pass  out  1  1 when all four vectors matched; held until next start
- err_count  out  3  number of mismatching vectors, 0..4
- fail_mask  out  4  bit i set when vector i mismatched

## Operation
- All outputs are registered. Reset values: A=0, B=0, busy=0, done=0, pass=0, err_count=0, fail_mask=0, state IDLE.
- FSM states: IDLE, SETTLE, SAMPLE, DONE.
- IDLE:
  - On start=1, clear err_count and fail_mask, set pass=0, busy=1, vector index=0, {A,B}=00 and settle counter=SETTLE-1.
  - Go to SETTLE.
- SETTLE:
  - Decrement the counter each cycle.
  - At 0, go to SAMPLE.
- SAMPLE:
  - Compare Y with TT[index] using case inequality; X or Z on Y counts as a mismatch.
  - On mismatch, set fail_mask[index] and increment err_count.
  - If index<3: increment index, drive the new {A,B}, reload counter=SETTLE-1 and go to SETTLE.
  - If index=3: go to DONE.
- DONE:
  - Assert done for one cycle, clear busy, set pass=(final err_count==0).
  - Return to IDLE.
- start while busy or in DONE is ignored.
- Vector order is fixed: 00, 01, 10, 11.
- The err_count increment uses the same-edge mismatch of vector 3, so the error is included in pass.

## Timing
- Edge 0 is the edge that samples start=1 in IDLE. A/B=00 and busy=1 are visible after edge 0.
- Each vector takes SETTLE+1 cycles. Vector i is sampled at edge (i+1)*(SETTLE+1).
- After the last sample, done=1, busy=0 and results are valid for the cycle following edge 4*(SETTLE+1)+1.
- With SETTLE=2: samples at edges 3, 6, 9, 12; done is high between edges 13 and 14.
- Back-to-back: start held high re-triggers on the first IDLE cycle after DONE.
- Reset asserted mid-sweep immediately forces every output to its reset value; no partial result is reported.
- A/B change only at the edge that leaves SAMPLE, never during SETTLE.

## Structure
- Package gate_check_pkg:
  - State enum.
  - Truth-table constants TT_AND=4'b1000, TT_OR=4'b1110, TT_NAND=4'b0111, TT_NOR=4'b0001, TT_XOR=4'b0110.
- One natural sub-module, settle_timer:
  - Loadable down-counter, 4 bits wide.
  - Inputs load and load value; output zero flag.
- FSM, vector index and result registers stay in the top module.

## Test plan
- TT=TT_OR, SETTLE=2, connected to OR gate, start pulse at edge 0 -> A/B sequence 00, 01, 10, 11; done at cycle 13; pass=1, err_count=0, fail_mask=0000.
- TT=TT_OR driving an AND gate -> err_count=2, fail_mask=0110, pass=0.
- Y tied to 0 with TT=TT_OR -> err_count=3, fail_mask=1110; Y left as X -> err_count=4, fail_mask=1111.
- start re-pulsed at edges 4 and 8 during a sweep -> no restart; done still at cycle 13; results unchanged.
- rst_n low at edge 5 mid-sweep -> all outputs are 0 asynchronously. New start after release -> full clean sweep with pass=1 on an OR gate.
- SETTLE=1 and SETTLE=15 with an OR gate -> samples at edges 2/4/6/8 and 16/32/48/64 respectively; pass=1.
